cbus_rr_arbiter: RTL and testbench

//   Parametrised N-requester arbiter for the cache bus (cbus_req_t / cbus_resp_t).
//   It merges icache, dcache, uncached and future walker or DMA masters onto the single

---
 rtl/cbus_rr_arbiter_pkg.sv | 21 ++
 rtl/cbus_rr_arbiter_if.sv | 20 ++
 rtl/cbus_rr_arbiter_arb_picker.sv | 44 ++++
 rtl/cbus_rr_arbiter.sv | 100 ++++++++++
 tb/tb_cbus_rr_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared types for the cache-bus arbiter: bus request/response structs and FSM state.
package cbus_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bundle of requester-side and memory-side cache-bus signals around the arbiter.
interface cbus_rr_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_INPUTS);

  cbus_req_t              ireqs  [NUM_INPUTS];
  cbus_resp_t             iresps [NUM_INPUTS];
  cbus_req_t              oreq;
  cbus_resp_t             oresp;
  logic [IDX_W-1:0]       grant_idx;
  logic                   busy;

  // master: the requesters and memory around the arbiter; slave: the arbiter itself
  modport master (output ireqs, oresp, input iresps, oreq, grant_idx, busy);
  modport slave  (input ireqs, oresp, output iresps, oreq, grant_idx, busy);

endinterface

// File: rtl/cbus_rr_arbiter_arb_picker.sv
// Combinational winner selection: starved requesters first, then rotating or fixed priority.
module arb_picker #(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_W-1:0]      rr_base,
  input  logic [NUM_INPUTS-1:0] starved,
  output logic [IDX_W-1:0]      winner,
  output logic                  found
);

  logic        starve_hit;
  int unsigned cand;

  // Loops run downward so the last match written is the lowest index / nearest to rr_base.
  always_comb begin
    winner     = '0;
    found      = |valid;
    starve_hit = 1'b0;
    cand       = 0;
    for (int unsigned i = NUM_INPUTS; i > 0; i--) begin
      if (valid[i-1] && starved[i-1]) begin
        winner     = IDX_W'(i-1);
        starve_hit = 1'b1;
      end
    end
    if (!starve_hit) begin
      if (ROUND_ROBIN != 0) begin
        for (int unsigned k = NUM_INPUTS; k > 0; k--) begin
          cand = 32'(rr_base) + k - 1;
          if (cand >= 32'(NUM_INPUTS)) cand = cand - 32'(NUM_INPUTS);
          if (valid[cand]) winner = IDX_W'(cand);
        end
      end else begin
        for (int unsigned i = NUM_INPUTS; i > 0; i--) begin
          if (valid[i-1]) winner = IDX_W'(i-1);
        end
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cache-bus arbiter: burst-locked grants, round-robin or fixed priority with starvation guard.
module cbus_rr_arbiter
  import cbus_arb_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int STARVE_MAX  = 15
) (
  input logic              clk,
  input logic              resetn,
  cbus_rr_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_CAP = CNT_W'(STARVE_MAX);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       rr_base;
  logic [CNT_W-1:0]       starve_cnt [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  valid_vec, starved_vec;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   owner_valid;
  logic                   leave;

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      valid_vec[i]   = bus.ireqs[i].valid;
      starved_vec[i] = (STARVE_MAX != 0) && (ROUND_ROBIN == 0) && (starve_cnt[i] == STARVE_CAP);
    end
  end

  arb_picker #(
    .NUM_INPUTS  (NUM_INPUTS),
    .ROUND_ROBIN (ROUND_ROBIN),
    .IDX_W       (IDX_W)
  ) u_picker (
    .valid   (valid_vec),
    .rr_base (rr_base),
    .starved (starved_vec),
    .winner  (pick_idx),
    .found   (pick_found)
  );

  assign leave         = bus.oresp.ready && bus.oresp.last;
  assign bus.grant_idx = grant_q;

  always_comb begin
    state_nxt   = state;
    bus.oreq    = '0;
    bus.busy    = 1'b0;
    owner_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) bus.iresps[i] = '0;
    case (state)
      ARB_IDLE: if (pick_found) state_nxt = ARB_BUSY;
      ARB_BUSY: begin
        bus.busy = 1'b1;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
          if (IDX_W'(i) == grant_q) begin
            bus.oreq      = bus.ireqs[i];
            owner_valid   = bus.ireqs[i].valid;
            bus.iresps[i] = bus.oresp;
          end
        end
        // grant is held for the whole burst even if the owner misbehaves
        bus.oreq.valid = 1'b1;
        if (leave) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      rr_base <= '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) starve_cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && pick_found) begin
        grant_q <= pick_idx;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
          if (IDX_W'(i) == pick_idx)   starve_cnt[i] <= '0;
          else if (valid_vec[i])       starve_cnt[i] <= (starve_cnt[i] == STARVE_CAP) ? starve_cnt[i] : starve_cnt[i] + 1'b1;
          else                         starve_cnt[i] <= '0;
        end
      end
      // explicit compare so non-power-of-two counts wrap to 0
      if (state == ARB_BUSY && leave)
        rr_base <= (grant_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_q + 1'b1;
      if (state == ARB_BUSY)
        owner_hold_chk: assert (owner_valid)
          else $warning("cbus_rr_arbiter: owner %0d dropped valid mid-burst", grant_q);
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboard bench for cbus_rr_arbiter: three configurations, directed stimulus, negedge monitor.
module tb_cbus_rr_arbiter;
  import cbus_arb_pkg::*;

  typedef struct {
    int idx;
    int beats;  // -1: not checked
    int gap;    // idle cycles since previous burst, -1: not checked
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t exp_q [3][$];
  exp_t cur [3];
  logic prev_busy [3] = '{1'b0, 1'b0, 1'b0};
  int   beats_c [3]   = '{0, 0, 0};
  int   gap_c [3]     = '{0, 0, 0};
  int   beat0 = 0, beat1 = 0, beat2 = 0;

  cbus_rr_arbiter_if #(.NUM_INPUTS(2)) b0 ();
  cbus_rr_arbiter_if #(.NUM_INPUTS(2)) b1 ();
  cbus_rr_arbiter_if #(.NUM_INPUTS(3)) b2 ();

  cbus_rr_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1), .STARVE_MAX(15)) u0 (.clk(clk), .resetn(resetn), .bus(b0));
  cbus_rr_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(0), .STARVE_MAX(2))  u1 (.clk(clk), .resetn(resetn), .bus(b1));
  cbus_rr_arbiter #(.NUM_INPUTS(3), .ROUND_ROBIN(1), .STARVE_MAX(15)) u2 (.clk(clk), .resetn(resetn), .bus(b2));

  // Zero-latency memory: ready every granted cycle, last on beat len, data = addr ^ beat.
  always @* begin
    b0.oresp.ready = b0.oreq.valid;
    b0.oresp.last  = b0.oreq.valid && (beat0 == int'(b0.oreq.len));
    b0.oresp.data  = b0.oreq.valid ? (b0.oreq.addr ^ 32'(beat0)) : 32'h0;
  end
  always @* begin
    b1.oresp.ready = b1.oreq.valid;
    b1.oresp.last  = b1.oreq.valid && (beat1 == int'(b1.oreq.len));
    b1.oresp.data  = b1.oreq.valid ? (b1.oreq.addr ^ 32'(beat1)) : 32'h0;
  end
  always @* begin
    b2.oresp.ready = b2.oreq.valid;
    b2.oresp.last  = b2.oreq.valid && (beat2 == int'(b2.oreq.len));
    b2.oresp.data  = b2.oreq.valid ? (b2.oreq.addr ^ 32'(beat2)) : 32'h0;
  end
  always @(posedge clk) begin
    beat0 <= (!resetn || !b0.oreq.valid || b0.oresp.last) ? 0 : beat0 + 1;
    beat1 <= (!resetn || !b1.oreq.valid || b1.oresp.last) ? 0 : beat1 + 1;
    beat2 <= (!resetn || !b2.oreq.valid || b2.oresp.last) ? 0 : beat2 + 1;
  end

  task automatic check(input int id, input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d, expected %0d (t=%0t)", id, name, act, exp, $time);
    end
  endtask

  task automatic mon(input int id, input logic bsy, input int gidx, input logic ov,
                     input logic [2:0] nz, input logic [95:0] dat, input logic [31:0] od, input int n);
    if (bsy && !prev_busy[id]) begin
      check(id, "grant_expected", longint'(exp_q[id].size() != 0), 1);
      if (exp_q[id].size() != 0) begin
        cur[id] = exp_q[id].pop_front();
        check(id, "grant_idx", gidx, cur[id].idx);
        if (cur[id].gap >= 0) check(id, "idle_gap", gap_c[id], cur[id].gap);
      end
      beats_c[id] = 0;
    end
    if (bsy) begin
      beats_c[id]++;
      check(id, "oreq_valid_busy", longint'(ov), 1);
      for (int i = 0; i < n; i++) begin
        if (i == cur[id].idx) check(id, "owner_resp_data", longint'(dat[i*32 +: 32]), longint'(od));
        else                  check(id, "nonowner_iresp", longint'(nz[i]), 0);
      end
    end else begin
      if (prev_busy[id]) begin
        if (cur[id].beats >= 0) check(id, "burst_beats", beats_c[id], cur[id].beats);
        gap_c[id] = 0;
      end
      gap_c[id]++;
      check(id, "idle_oreq_valid", longint'(ov), 0);
      check(id, "idle_iresps", longint'(nz), 0);
    end
    prev_busy[id] = bsy;
  endtask

  always @(negedge clk) begin
    mon(0, b0.busy, int'(b0.grant_idx), b0.oreq.valid,
        {1'b0, |b0.iresps[1], |b0.iresps[0]}, {32'h0, b0.iresps[1].data, b0.iresps[0].data}, b0.oresp.data, 2);
    mon(1, b1.busy, int'(b1.grant_idx), b1.oreq.valid,
        {1'b0, |b1.iresps[1], |b1.iresps[0]}, {32'h0, b1.iresps[1].data, b1.iresps[0].data}, b1.oresp.data, 2);
    mon(2, b2.busy, int'(b2.grant_idx), b2.oreq.valid,
        {|b2.iresps[2], |b2.iresps[1], |b2.iresps[0]},
        {b2.iresps[2].data, b2.iresps[1].data, b2.iresps[0].data}, b2.oresp.data, 3);
  end

  function automatic cbus_req_t mk_req(input logic v, input logic [7:0] len, input logic [31:0] addr);
    cbus_req_t r;
    r = '0;
    r.valid = v;
    r.len   = len;
    r.addr  = addr;
    r.data  = ~addr;
    r.strb  = 4'hf;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input int idx, input int beats, input int gap);
    exp_t e;
    e.idx = idx; e.beats = beats; e.gap = gap;
    exp_q[id].push_back(e);
  endtask

  task automatic wait_drain(input int id);
    for (int c = 0; c < 200 && exp_q[id].size() != 0; c++) tick(1);
    check(id, "drain_timeout", exp_q[id].size(), 0);
  endtask

  function automatic logic busy_of(input int id);
    case (id)
      0:       return b0.busy;
      1:       return b1.busy;
      default: return b2.busy;
    endcase
  endfunction

  task automatic wait_idle(input int id);
    for (int c = 0; c < 200 && busy_of(id); c++) tick(1);
    check(id, "idle_timeout", longint'(busy_of(id)), 0);
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin b0.ireqs[i] = '0; b1.ireqs[i] = '0; end
    for (int i = 0; i < 3; i++) b2.ireqs[i] = '0;
    tick(3);
    check(0, "rst_busy", longint'(b0.busy), 0);
    check(0, "rst_oreq", longint'(|b0.oreq), 0);
    check(0, "rst_grant", longint'(b0.grant_idx), 0);
    check(1, "rst_busy", longint'(b1.busy), 0);
    check(2, "rst_grant", longint'(b2.grant_idx), 0);
    resetn = 1'b1;
    tick(1);

    // RR alternation, 4-beat bursts, one idle cycle between grants
    push(0, 0, 4, -1); push(0, 1, 4, 1); push(0, 0, 4, 1); push(0, 1, 4, 1);
    b0.ireqs[0] = mk_req(1'b1, 8'd3, 32'h0000_1000);
    b0.ireqs[1] = mk_req(1'b1, 8'd3, 32'h0000_2000);
    wait_drain(0); wait_idle(0);
    b0.ireqs[0] = '0; b0.ireqs[1] = '0;
    tick(2);

    // fixed priority with STARVE_MAX=2: req1 wins after two losses
    push(1, 0, 2, -1); push(1, 0, 2, 1); push(1, 1, 2, 1); push(1, 0, 2, 1);
    b1.ireqs[0] = mk_req(1'b1, 8'd1, 32'h0000_3000);
    b1.ireqs[1] = mk_req(1'b1, 8'd1, 32'h0000_4000);
    wait_drain(1); wait_idle(1);
    b1.ireqs[0] = '0; b1.ireqs[1] = '0;
    tick(2);

    // N=3 RR: rr_base wraps 2 -> 0
    push(2, 2, 1, -1);
    b2.ireqs[2] = mk_req(1'b1, 8'd0, 32'h0000_5000);
    wait_drain(2); wait_idle(2);
    push(2, 0, 1, 1); push(2, 1, 1, 1);
    b2.ireqs[2] = '0;
    b2.ireqs[0] = mk_req(1'b1, 8'd0, 32'h0000_6000);
    b2.ireqs[1] = mk_req(1'b1, 8'd0, 32'h0000_7000);
    wait_drain(2); wait_idle(2);
    b2.ireqs[0] = '0; b2.ireqs[1] = '0;
    check(2, "rr_base_after", longint'(u2.rr_base), 2);
    tick(2);

    // single-beat read: busy exactly one cycle
    push(0, 0, 1, -1);
    b0.ireqs[0] = mk_req(1'b1, 8'd0, 32'h0000_8A5C);
    wait_drain(0); wait_idle(0);
    b0.ireqs[0] = '0;
    tick(2);

    // reset during 2nd beat of a 4-beat burst from req1
    push(0, 1, -1, -1);
    b0.ireqs[1] = mk_req(1'b1, 8'd3, 32'h0000_9000);
    tick(2);
    check(0, "busy_before_reset", longint'(b0.busy), 1);
    resetn = 1'b0;
    b0.ireqs[1] = '0;
    tick(1);
    check(0, "rst_mid_busy", longint'(b0.busy), 0);
    check(0, "rst_mid_oreq_valid", longint'(b0.oreq.valid), 0);
    check(0, "rst_mid_grant", longint'(b0.grant_idx), 0);
    check(0, "rst_mid_rr_base", longint'(u0.rr_base), 0);
    resetn = 1'b1;
    tick(2);

    // owner drops valid mid-burst: grant held for all 4 beats
    push(0, 0, 4, -1);
    b0.ireqs[0] = mk_req(1'b1, 8'd3, 32'h0000_A000);
    tick(2);
    b0.ireqs[0].valid = 1'b0;
    wait_drain(0); wait_idle(0);
    tick(5);

    for (int id = 0; id < 3; id++) check(id, "queue_empty", exp_q[id].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
